// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Decides each cycle whether the front end holds, whether ID/EX takes a bubble,
// and whether the whole pipeline freezes behind a busy data memory.
// Also tracks the memory-wait timeout and counts stall cycles.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | no outstanding memory wait; branch/hazard logic active
// MEM_WAIT | data memory access in flight; pipeline frozen until ready or
//          | the wait timer hits terminal count (then mem_err, back to RUN)
module hazard_stall_ctrl #(
   parameter bit FWD_EN  = 1'b1,
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 200,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       src1,
   input  logic [4:0]       src2,
   input  logic             two_src,
   input  logic [4:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [4:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic             br_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             freeze_if,
   output logic             flush_if,
   output logic             bubble_id,
   output logic             freeze_all,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

   state_t          state;
   logic [TO_W-1:0] to_cnt;
   logic            exe_raw;
   logic            mem_raw;
   logic            hazard;
   logic            to_hit;
   logic            mem_busy;

   // Source/destination matches; $0 is hardwired zero and never a dependency.
   assign exe_raw = ((src1 != 5'd0) && (src1 == exe_dest)) ||
                    (two_src && (src2 != 5'd0) && (src2 == exe_dest));
   assign mem_raw = ((src1 != 5'd0) && (src1 == mem_dest)) ||
                    (two_src && (src2 != 5'd0) && (src2 == mem_dest));

   // With forwarding only a load in EXE must stall; without it any pending write does.
   always_comb begin
      hazard = 1'b0;
      if (FWD_EN) hazard = exe_mem_r_en && exe_raw;
      else        hazard = (exe_wb_en && exe_raw) || (mem_wb_en && mem_raw);
   end

   // The wait timer counts down from TIMEOUT; reaching zero in MEM_WAIT releases
   // the freeze for that cycle as if the memory had answered.
   assign to_hit   = (state == MEM_WAIT) && (to_cnt == '0);
   assign mem_busy = ((state == RUN) && mem_req && !mem_ready) ||
                     ((state == MEM_WAIT) && !mem_ready && !to_hit);

   // Control lines: memory freeze beats branch flush beats hazard stall.
   always_comb begin
      freeze_if  = 1'b0;
      flush_if   = 1'b0;
      bubble_id  = 1'b0;
      freeze_all = 1'b0;
      if (!rst) begin
         if (mem_busy) begin
            freeze_all = 1'b1;
         end else if (br_taken) begin
            flush_if  = 1'b1;
            bubble_id = 1'b1;
         end else if (hazard) begin
            freeze_if = 1'b1;
            bubble_id = 1'b1;
         end
      end
   end

   // Memory-wait FSM with timeout timer and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         to_cnt  <= '0;
         mem_err <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_req && !mem_ready) begin
                  state  <= MEM_WAIT;
                  to_cnt <= TO_W'(TIMEOUT);
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state <= RUN;
               end else if (to_cnt == '0) begin
                  mem_err <= 1'b1;
                  state   <= RUN;
               end else begin
                  to_cnt <= to_cnt - 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // Saturating count of cycles spent stalled or frozen.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((freeze_if || freeze_all) && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
